pipe_addsub: RTL and testbench

Parametrised, fully pipelined ripple-segment adder/subtractor. A WIDTH-bit operation is split into NSEG = WIDTH/SEG segments, with one segment resolved per pipeline stage. The block accepts one operation per cycle, carries per-operation mode, valid and stall control, and produces sum, carry-out and signed overflow. It is the general arithmetic pipe for datapaths that previously used the fixed 16-bit four-stage adder.

---
 rtl/pipe_addsub_if.sv | 41 ++++
 rtl/pipe_addsub.sv | 116 +++++++++++
 tb/tb_pipe_addsub.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_addsub_if.sv
// pipe_addsub_if: operand/result bundle for the pipelined adder/subtractor.
//
// Signals (master = upstream producer/consumer, slave = pipe_addsub):
//   en        global pipeline enable; 0 freezes every pipeline register
//   in_valid  an operation is present on a/b/cin/sub this cycle
//   a, b      WIDTH-bit operands
//   cin       carry-in (ignored when sub=1)
//   sub       0: a+b+cin, 1: a-b
//   sum       registered result
//   cout      carry out of the MSB (for subtract: 1 = no borrow)
//   ovf       signed overflow of the operation
//   out_valid sum/cout/ovf hold a completed operation
//
// Handshake: valid-only, no backpressure. An operation transfers on a rising
// clk edge where en=1 and in_valid=1; when en=0 nothing transfers and the
// producer must hold its inputs. out_valid is high for exactly one enabled
// cycle per accepted operation, and outputs hold while en=0.
interface pipe_addsub_if #(
  parameter int WIDTH = 32
) ();
  logic             en;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             out_valid;

  modport master (
    output en, in_valid, a, b, cin, sub,
    input  sum, cout, ovf, out_valid
  );

  modport slave (
    input  en, in_valid, a, b, cin, sub,
    output sum, cout, ovf, out_valid
  );
endinterface

// File: rtl/pipe_addsub.sv
// pipe_addsub: fully pipelined ripple-segment adder/subtractor.
//
// A WIDTH-bit add is split into NSEG = WIDTH/SEG segments; stage k adds
// segment k plus the carry registered by stage k-1. Latency is NSEG enabled
// edges (the capture edge counts as the first), throughput one op per
// enabled cycle. WIDTH must be a multiple of SEG.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; clears all state, drops in-flight ops
//   bus  pipe_addsub_if.slave (en, in_valid, a, b, cin, sub -> sum, cout,
//        ovf, out_valid)
//
// Each stage k keeps two things:
//   sum_q  : the (k+1)*SEG low result bits already resolved (de-skew)
//   ra_q/rb_q : the operand bits not yet added (skew), dropping one segment
//               per stage, so segment k meets its carry at stage k.
module pipe_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG   = 4
) (
  input  logic         clk,
  input  logic         rst,
  pipe_addsub_if.slave bus
);
  localparam int NSEG = WIDTH / SEG;

  // Subtract is a + ~b + 1, so the mode is folded in before stage 0.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign b_eff   = bus.sub ? ~bus.b : bus.b;
  assign cin_eff = bus.sub | bus.cin;

  for (genvar k = 0; k < NSEG; k++) begin : g_st
    localparam int RIW = WIDTH - k * SEG;  // operand bits arriving at stage k
    localparam int SW  = (k + 1) * SEG;    // result bits resolved after stage k

    logic [RIW-1:0] ra_in;
    logic [RIW-1:0] rb_in;
    logic           c_in;
    logic           v_in;
    logic [SEG:0]   seg_sum;
    logic [SW-1:0]  sum_d;
    logic [SW-1:0]  sum_q;
    logic           c_q;
    logic           v_q;

    if (k == 0) begin : g_first
      assign ra_in = bus.a;
      assign rb_in = b_eff;
      assign c_in  = cin_eff;
      assign v_in  = bus.in_valid;
      assign sum_d = seg_sum[SEG-1:0];
    end else begin : g_chain
      assign ra_in = g_st[k-1].g_rem.ra_q;
      assign rb_in = g_st[k-1].g_rem.rb_q;
      assign c_in  = g_st[k-1].c_q;
      assign v_in  = g_st[k-1].v_q;
      assign sum_d = {seg_sum[SEG-1:0], g_st[k-1].sum_q};
    end

    // One SEG-bit ripple per stage; seg_sum[SEG] is the carry to stage k+1.
    assign seg_sum = {1'b0, ra_in[SEG-1:0]} + {1'b0, rb_in[SEG-1:0]}
                   + {{SEG{1'b0}}, c_in};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_q <= '0;
        c_q   <= 1'b0;
        v_q   <= 1'b0;
      end else if (bus.en) begin
        sum_q <= sum_d;
        c_q   <= seg_sum[SEG];
        v_q   <= v_in;
      end
    end

    // The last stage consumes its operands directly, so it has no remainder.
    if (k < NSEG - 1) begin : g_rem
      logic [RIW-SEG-1:0] ra_q;
      logic [RIW-SEG-1:0] rb_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ra_q <= '0;
          rb_q <= '0;
        end else if (bus.en) begin
          ra_q <= ra_in[RIW-1:SEG];
          rb_q <= rb_in[RIW-1:SEG];
        end
      end
    end
  end

  // The top segment of the last stage still carries the MSBs of a and b_eff,
  // so the signed overflow is decided there alongside the final ripple.
  logic ovf_d;
  logic ovf_q;

  assign ovf_d = (g_st[NSEG-1].ra_in[SEG-1] == g_st[NSEG-1].rb_in[SEG-1])
              && (g_st[NSEG-1].seg_sum[SEG-1] != g_st[NSEG-1].ra_in[SEG-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (bus.en) begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.sum       = g_st[NSEG-1].sum_q;
  assign bus.cout      = g_st[NSEG-1].c_q;
  assign bus.out_valid = g_st[NSEG-1].v_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipe_addsub.sv
// Testbench for pipe_addsub with WIDTH=16, SEG=4 (latency 4 enabled edges).
module tb_pipe_addsub;
  localparam int WIDTH = 16;
  localparam int SEG   = 4;
  localparam int LAT   = WIDTH / SEG;
  localparam int SLW   = WIDTH + 3;  // slot: {valid, sum, cout, ovf}

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ov;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipe_addsub_if #(.WIDTH(WIDTH)) bus ();

  pipe_addsub #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [SLW-1:0]   exp_q[$];
  int               n_cmp = 0;
  int               n_bad = 0;
  logic [WIDTH-1:0] prev_sum;
  logic             prev_cout;
  logic             prev_ovf;
  logic             prev_ov;
  vec_t             vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [SLW-1:0] model(input logic v, input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b, input logic cin,
                                           input logic sub);
    logic [WIDTH-1:0] be;
    logic [WIDTH:0]   t;
    logic             ov;
    be = sub ? ~b : b;
    t  = {1'b0, a} + {1'b0, be} + {{WIDTH{1'b0}}, (sub ? 1'b1 : cin)};
    ov = (a[WIDTH-1] == be[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
    return {v, t[WIDTH-1:0], t[WIDTH], ov};
  endfunction

  task automatic snapshot();
    prev_sum  = bus.sum;
    prev_cout = bus.cout;
    prev_ovf  = bus.ovf;
    prev_ov   = bus.out_valid;
  endtask

  task automatic prime();
    exp_q.delete();
    for (int i = 0; i < LAT - 1; i++) exp_q.push_back('0);
  endtask

  // ---------------- driver ----------------
  // Drive one cycle; the slot is the expected output for this op, which
  // emerges LAT enabled edges later (the queue holds LAT-1 older slots).
  task automatic drive(input logic en, input logic v, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic cin, input logic sub,
                       input logic [SLW-1:0] slot);
    logic [SLW-1:0] e;
    bus.en       = en;
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.sub      = sub;
    @(posedge clk);
    #1;
    if (en) begin
      exp_q.push_back(slot);
      e = exp_q.pop_front();
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, e[SLW-1]});
      if (e[SLW-1]) begin
        check("sum", {16'd0, bus.sum}, {16'd0, e[SLW-2:2]});
        check("cout", {31'd0, bus.cout}, {31'd0, e[1]});
        check("ovf", {31'd0, bus.ovf}, {31'd0, e[0]});
      end
    end else begin
      check("stall_sum", {16'd0, bus.sum}, {16'd0, prev_sum});
      check("stall_cout", {31'd0, bus.cout}, {31'd0, prev_cout});
      check("stall_ovf", {31'd0, bus.ovf}, {31'd0, prev_ovf});
      check("stall_valid", {31'd0, bus.out_valid}, {31'd0, prev_ov});
    end
    snapshot();
  endtask

  task automatic issue_vec(input vec_t v);
    drive(1'b1, 1'b1, v.a, v.b, v.cin, v.sub, {1'b1, v.s, v.co, v.ov});
  endtask

  task automatic bubble(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b1, 1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b0, '0);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [7:0]       pat;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rc;
    logic             rs;

    vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[2]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[3]  = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4]  = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
    vecs[5]  = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[8]  = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[9]  = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[10] = '{16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b1};
    vecs[11] = '{16'h0005, 16'hFFFB, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};

    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.cin      = 1'b0;
    bus.sub      = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_sum", {16'd0, bus.sum}, 32'd0);
    check("reset_cout", {31'd0, bus.cout}, 32'd0);
    check("reset_ovf", {31'd0, bus.ovf}, 32'd0);
    check("reset_valid", {31'd0, bus.out_valid}, 32'd0);
    rst = 1'b0;
    prime();
    snapshot();

    // Directed table, back-to-back, then drain.
    for (int i = 0; i < 12; i++) issue_vec(vecs[i]);
    bubble(LAT);

    // Streaming with bubbles, random operands, pattern 1,1,0,1,1,1,0,1.
    pat = 8'b1011_1011;
    for (int i = 0; i < 8; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      drive(1'b1, pat[i], ra, rb, rc, rs, model(pat[i], ra, rb, rc, rs));
    end
    bubble(LAT);

    // Stall: capture, one enabled edge, 3 stalled cycles, then two more
    // enabled edges -> result visible after the 7th edge.
    issue_vec(vecs[4]);
    bubble(1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    bubble(2);
    check("stall_latency_valid", {31'd0, bus.out_valid}, 32'd1);
    check("stall_latency_sum", {16'd0, bus.sum}, 32'h2345);
    bubble(LAT);

    // Async reset mid-stream while an op (7FFF, cout=1, ovf=1) is visible.
    issue_vec(vecs[0]);
    issue_vec(vecs[1]);
    issue_vec(vecs[2]);
    issue_vec(vecs[4]);
    issue_vec(vecs[5]);
    issue_vec(vecs[6]);
    check("pre_reset_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = 16'h4444;
    bus.b        = 16'h1111;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("async_rst_sum", {16'd0, bus.sum}, 32'd0);
    check("async_rst_cout", {31'd0, bus.cout}, 32'd0);
    check("async_rst_ovf", {31'd0, bus.ovf}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("held_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    rst = 1'b0;
    prime();
    snapshot();
    bubble(6);
    issue_vec(vecs[5]);
    bubble(LAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
